// File: rtl/prbs_pkg.sv
// prbs_pkg: definitions shared by the PRBS generator and checker.
//   - PRBS_PN_LIST : polynomial orders the PRBS blocks support
//   - prbs_taps()  : feedback tap mask for a given order, bit k-1 set for x^k
//   - prbs_pn_legal(): whether an order is in the supported list
//   - prbs_chk_state_t : checker alignment state
package prbs_pkg;

    localparam int unsigned PRBS_MAX_PN = 41;
    localparam int unsigned PRBS_NUM_PN = 14;

    localparam int unsigned PRBS_PN_LIST [PRBS_NUM_PN] =
        '{3, 4, 5, 6, 7, 9, 11, 15, 17, 23, 31, 32, 36, 41};

    typedef logic [PRBS_MAX_PN-1:0] prbs_mask_t;

    typedef enum logic [1:0] {
        SEED,
        SYNC,
        LOCKED
    } prbs_chk_state_t;

    // Register convention: lfsr[0] is the newest bit, lfsr[k-1] is the bit
    // from k steps ago, so tap x^k selects lfsr[k-1].
    function automatic prbs_mask_t prbs_taps(input int unsigned pn);
        prbs_mask_t m;
        m = '0;
        case (pn)
            3:  begin m[2]  = 1'b1; m[1]  = 1'b1; end
            4:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
            5:  begin m[4]  = 1'b1; m[2]  = 1'b1; end
            6:  begin m[5]  = 1'b1; m[4]  = 1'b1; end
            7:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
            9:  begin m[8]  = 1'b1; m[4]  = 1'b1; end
            11: begin m[10] = 1'b1; m[8]  = 1'b1; end
            15: begin m[14] = 1'b1; m[13] = 1'b1; end
            17: begin m[16] = 1'b1; m[13] = 1'b1; end
            23: begin m[22] = 1'b1; m[17] = 1'b1; end
            31: begin m[30] = 1'b1; m[27] = 1'b1; end
            32: begin m[31] = 1'b1; m[21] = 1'b1; m[1] = 1'b1; m[0] = 1'b1; end
            36: begin m[35] = 1'b1; m[24] = 1'b1; end
            41: begin m[40] = 1'b1; m[37] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic bit prbs_pn_legal(input int unsigned pn);
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < PRBS_NUM_PN; i++) begin
            if (PRBS_PN_LIST[i] == pn) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: next PRBS bit predicted from the last PN bits.
//   PN   : polynomial order
//   lfsr : history, lfsr[0] newest
//   pred : XOR of the polynomial taps, i.e. the next bit of the sequence
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int unsigned PN = 7
) (
    input  logic [PN-1:0] lfsr,
    output logic          pred
);

    localparam logic [PN-1:0] TAPS = PN'(prbs_taps(PN));

    assign pred = ^(lfsr & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS bit-error detector.
//   i_clk      : clock, rising edge
//   i_a_rst_n  : asynchronous active-low reset
//   i_en       : i_data valid this cycle; all state holds when low
//   i_data     : received serial PRBS bit
//   i_clr      : synchronous clear of both counters (independent of i_en)
//   o_lock     : local LFSR aligned to the incoming stream
//   o_err      : one-cycle pulse per errored bit while locked
//   o_err_cnt  : saturating errored-bit count
//   o_bit_cnt  : saturating count of bits checked while locked
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned PN          = 7,
    parameter bit          INV         = 1'b0,
    parameter int unsigned LOCK_CNT    = 32,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_a_rst_n,
    input  logic             i_en,
    input  logic             i_data,
    input  logic             i_clr,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam int unsigned SEED_W  = $clog2(PN + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
    localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

    prbs_chk_state_t    state_q, state_d;
    logic [PN-1:0]      lfsr_q, lfsr_d;
    logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]   win_bit_q, win_bit_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [WERR_W-1:0]  win_err_inc;
    logic               d;
    logic               pred;
    logic               bit_err;
    logic               bit_chk;

    assign d = i_data ^ INV;

    prbs_lfsr_step #(.PN(PN)) u_step (
        .lfsr (lfsr_q),
        .pred (pred)
    );

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_bit_d   = win_bit_q;
        win_err_d   = win_err_q;
        win_err_inc = win_err_q;
        bit_err     = 1'b0;
        bit_chk     = 1'b0;

        if (i_en) begin
            case (state_q)
                SEED: begin
                    lfsr_d = {lfsr_q[PN-2:0], d};
                    if (seed_cnt_q == SEED_W'(PN - 1)) begin
                        seed_cnt_d = '0;
                        // All-zero history is the LFSR lockup state: reseed.
                        if (lfsr_d != '0) begin
                            state_d     = SYNC;
                            match_cnt_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end

                SYNC: begin
                    if (d == pred) begin
                        lfsr_d = {lfsr_q[PN-2:0], d};
                        if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d   = LOCKED;
                            win_bit_d = '0;
                            win_err_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        // Mismatching bit is dropped; seeding restarts next bit.
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    // Free-run on the prediction so input errors cannot
                    // corrupt the local sequence.
                    lfsr_d      = {lfsr_q[PN-2:0], pred};
                    bit_chk     = 1'b1;
                    bit_err     = d ^ pred;
                    win_err_inc = win_err_q + WERR_W'(bit_err);
                    if (win_err_inc == WERR_W'(UNLOCK_ERRS)) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                        win_bit_d  = '0;
                        win_err_d  = '0;
                    end else if (win_bit_q == WIN_W'(WINDOW - 1)) begin
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_bit_d = win_bit_q + WIN_W'(1);
                        win_err_d = win_err_inc;
                    end
                end

                default: begin
                    state_d    = SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q     <= SEED;
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            o_lock      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            o_lock      <= (state_d == LOCKED);
            o_err       <= bit_err;
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            o_err_cnt <= '0;
            o_bit_cnt <= '0;
        end else if (i_clr) begin
            o_err_cnt <= '0;
            o_bit_cnt <= '0;
        end else begin
            if (bit_err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + CNT_W'(1);
            if (bit_chk && (o_bit_cnt != '1)) o_bit_cnt <= o_bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker with a PN7 stream source.
// Three instances share the stimulus: defaults, INV = 1, and CNT_W = 4.
module tb_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        data;
    logic        clr;

    logic        lock, err;
    logic [31:0] err_cnt, bit_cnt;
    logic        inv_lock, inv_err;
    logic [31:0] inv_err_cnt, inv_bit_cnt;
    logic        c4_lock, c4_err;
    logic [3:0]  c4_err_cnt, c4_bit_cnt;

    prbs_checker dut (
        .i_clk (clk), .i_a_rst_n (rst_n), .i_en (en), .i_data (data), .i_clr (clr),
        .o_lock (lock), .o_err (err), .o_err_cnt (err_cnt), .o_bit_cnt (bit_cnt)
    );

    prbs_checker #(.INV(1'b1)) dut_inv (
        .i_clk (clk), .i_a_rst_n (rst_n), .i_en (en), .i_data (data), .i_clr (clr),
        .o_lock (inv_lock), .o_err (inv_err), .o_err_cnt (inv_err_cnt), .o_bit_cnt (inv_bit_cnt)
    );

    prbs_checker #(.CNT_W(4)) dut_c4 (
        .i_clk (clk), .i_a_rst_n (rst_n), .i_en (en), .i_data (data), .i_clr (clr),
        .o_lock (c4_lock), .o_err (c4_err), .o_err_cnt (c4_err_cnt), .o_bit_cnt (c4_bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // PN7 source, x^7 + x^6 + 1, g[0] newest
    logic [6:0]  g;
    logic        zero_mode, inv_mode;

    int unsigned nbits, lock_at, inv_lock_at, c4_lock_at;
    int unsigned err_pulses, inv_err_pulses;
    logic        any_lock, inv_any_lock, idle_err, idle_unlock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_stats();
        nbits = 0; lock_at = 0; inv_lock_at = 0; c4_lock_at = 0;
        err_pulses = 0; inv_err_pulses = 0;
        any_lock = 1'b0; inv_any_lock = 1'b0;
        idle_err = 1'b0; idle_unlock = 1'b0;
    endtask

    task automatic send(input logic flip);
        logic b;
        b    = g[6] ^ g[5];
        en   = 1'b1;
        data = zero_mode ? 1'b0 : (b ^ inv_mode ^ flip);
        @(posedge clk);
        #1;
        g = {g[5:0], b};
        nbits++;
        if (lock     && lock_at     == 0) lock_at     = nbits;
        if (inv_lock && inv_lock_at == 0) inv_lock_at = nbits;
        if (c4_lock  && c4_lock_at  == 0) c4_lock_at  = nbits;
        if (lock)     any_lock     = 1'b1;
        if (inv_lock) inv_any_lock = 1'b1;
        if (err)      err_pulses++;
        if (inv_err)  inv_err_pulses++;
    endtask

    task automatic idle();
        en   = 1'b0;
        data = 1'($urandom);
        @(posedge clk);
        #1;
        if (err)   idle_err    = 1'b1;
        if (!lock) idle_unlock = 1'b1;
    endtask

    // Called between edges so the output checks observe the asynchronous path.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        #2;
        check({tag, "_lock"},    64'(lock),       64'd0);
        check({tag, "_err"},     64'(err),        64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt),    64'd0);
        check({tag, "_bit_cnt"}, 64'(bit_cnt),    64'd0);
        check({tag, "_c4_cnt"},  64'(c4_err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned exp_bits;
        rst_n = 1'b1; en = 1'b0; data = 1'b0; clr = 1'b0;
        g = 7'h01; zero_mode = 1'b0; inv_mode = 1'b0;
        #1;
        do_reset("rst0");

        // Clean stream: lock after 7 + 32 bits, 961 locked bits
        clear_stats();
        repeat (1000) send(1'b0);
        check("p1_lock_lat",   64'(lock_at),      64'd39);
        check("p1_err_pulses", 64'(err_pulses),   64'd0);
        check("p1_err_cnt",    64'(err_cnt),      64'd0);
        check("p1_bit_cnt",    64'(bit_cnt),      64'd961);
        check("p1_c4_lock",    64'(c4_lock_at),   64'd39);
        check("p1_c4_bit_sat", 64'(c4_bit_cnt),   64'd15);
        check("p1_inv_nolock", 64'(inv_any_lock), 64'd0);

        // Single inverted bit
        clear_stats();
        for (int i = 1; i <= 250; i++) begin
            send(i == 200);
            if (i == 200) check("p2_err_pulse", 64'(err), 64'd1);
            if (i == 201) check("p2_next_clean", 64'(err), 64'd0);
        end
        check("p2_err_pulses", 64'(err_pulses), 64'd1);
        check("p2_err_cnt",    64'(err_cnt),    64'd1);
        check("p2_lock",       64'(lock),       64'd1);
        check("p2_bit_cnt",    64'(bit_cnt),    64'd1211);

        // i_en toggling every 128 cycles
        clear_stats();
        exp_bits = 1211;
        for (int blk = 0; blk < 5; blk++) begin
            if (blk % 2 == 0) begin
                repeat (128) send(1'b0);
                exp_bits += 128;
            end else begin
                repeat (128) idle();
                check("p3_hold_bits", 64'(bit_cnt), 64'(exp_bits));
            end
        end
        check("p3_idle_err",    64'(idle_err),    64'd0);
        check("p3_idle_unlock", 64'(idle_unlock), 64'd0);
        check("p3_err_pulses",  64'(err_pulses),  64'd0);
        check("p3_err_cnt",     64'(err_cnt),     64'd1);
        check("p3_bit_cnt",     64'(bit_cnt),     64'd1595);

        // Burst of 8 errors in one window forces unlock, then relock
        do_reset("rst4");
        clear_stats();
        repeat (39) send(1'b0);
        check("p4_lock_lat", 64'(lock_at), 64'd39);
        clear_stats();
        for (int i = 1; i <= 24; i++) begin
            send(i % 3 == 0);
            if (i == 21) check("p4_lock_7th", 64'(lock), 64'd1);
            if (i == 24) check("p4_unlock_8th", 64'(lock), 64'd0);
        end
        check("p4_err_pulses", 64'(err_pulses), 64'd8);
        check("p4_err_cnt",    64'(err_cnt),    64'd8);
        check("p4_bit_cnt",    64'(bit_cnt),    64'd24);
        clear_stats();
        repeat (60) send(1'b0);
        check("p4_relock_lat", 64'(lock_at), 64'd39);
        check("p4_err_kept",   64'(err_cnt), 64'd8);
        check("p4_bit_cnt2",   64'(bit_cnt), 64'd45);

        // All-zero stream never locks
        do_reset("rst5");
        zero_mode = 1'b1;
        clear_stats();
        repeat (500) send(1'b0);
        check("p5_zero_nolock",     64'(any_lock),     64'd0);
        check("p5_zero_inv_nolock", 64'(inv_any_lock), 64'd0);
        check("p5_zero_err_cnt",    64'(err_cnt),      64'd0);
        check("p5_zero_bit_cnt",    64'(bit_cnt),      64'd0);
        check("p5_zero_inv_bits",   64'(inv_bit_cnt),  64'd0);
        zero_mode = 1'b0;

        // Inverted stream: INV = 0 never locks, INV = 1 locks normally
        do_reset("rst5b");
        inv_mode = 1'b1;
        clear_stats();
        repeat (500) send(1'b0);
        check("p5_n_nolock",    64'(any_lock),       64'd0);
        check("p5_n_err_cnt",   64'(err_cnt),        64'd0);
        check("p5_n_bit_cnt",   64'(bit_cnt),        64'd0);
        check("p5_inv_lat",     64'(inv_lock_at),    64'd39);
        check("p5_inv_pulses",  64'(inv_err_pulses), 64'd0);
        check("p5_inv_err_cnt", 64'(inv_err_cnt),    64'd0);
        check("p5_inv_bit_cnt", 64'(inv_bit_cnt),    64'd461);
        inv_mode = 1'b0;

        // Sparse errors, 4 per window: 4-bit counter saturates
        do_reset("rst6");
        clear_stats();
        repeat (39) send(1'b0);
        check("p6_c4_lock_lat", 64'(c4_lock_at), 64'd39);
        clear_stats();
        for (int i = 1; i <= 320; i++) send(i % 16 == 8);
        check("p6_c4_err_sat", 64'(c4_err_cnt), 64'd15);
        check("p6_err_cnt",    64'(err_cnt),    64'd20);
        check("p6_err_pulses", 64'(err_pulses), 64'd20);
        check("p6_lock",       64'(lock),       64'd1);
        check("p6_c4_lock",    64'(c4_lock),    64'd1);

        // Clear in the same cycle as an error wins over the increment
        clr = 1'b1;
        send(1'b1);
        clr = 1'b0;
        check("p6_clr_c4_err", 64'(c4_err_cnt), 64'd0);
        check("p6_clr_err",    64'(err_cnt),    64'd0);
        check("p6_clr_bits",   64'(bit_cnt),    64'd0);
        check("p6_clr_pulse",  64'(c4_err),     64'd1);
        check("p6_clr_lock",   64'(c4_lock),    64'd1);
        repeat (3) send(1'b0);
        check("p6_post_bits",  64'(bit_cnt),    64'd3);
        check("p6_post_err",   64'(err_cnt),    64'd0);

        // Clear while i_en is low
        clr = 1'b1;
        idle();
        clr = 1'b0;
        check("p6_idle_clr_bits", 64'(bit_cnt), 64'd0);
        check("p6_idle_clr_lock", 64'(lock),    64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
